alu_issue_queue: RTL
====================

Name: alu_issue_queue

Overview:
- Data-capture issue queue directly upstream of the single-cycle ALU functional unit.
- Accepts renamed ALU micro-ops from dispatch and holds them until both source operands are available.
- Captures operand values from the writeback broadcast and issues at most one ready micro-op per cycle, oldest first, as a registered fu_input_t.

Parameters:
- DEPTH, 8, number of queue entries (power of two, 2..16).
- PRW, 6, physical register tag width (matches width of prd in fu_input_t/fu_output_t).

Ports:
- clk  in  1  clock.
- rstn  in  1  asynchronous active-low reset.
- flush_i  in  1  kill all queued and in-flight issue state.
- disp_valid_i  in  1  dispatch offers a micro-op.
- disp_ready_o  out  1  queue can accept this cycle.
- disp_uop_i  in  fu_input_t  micro-op; rs1val/rs2val valid only where the matching rdy bit is set.
- disp_prs1_i, disp_prs2_i  in  PRW each  source tags.
- disp_rs1_rdy_i, disp_rs2_rdy_i  in  1 each  operand value already present in disp_uop_i.
- wb_valid_i  in  1  writeback broadcast valid.
- wb_i  in  fu_output_t  broadcast: prd tag plus rdval.
- issue_valid_o  out  1  fuinput_o valid this cycle.
- fuinput_o  out  fu_input_t  registered micro-op to ALU.
- count_o  out  $clog2(DEPTH)+1  occupied entries.

Behaviour:
- Reset (async, rstn low): all entry valid bits 0, count_o=0, issue_valid_o=0, fuinput_o='0. disp_ready_o=1 once out of reset.
- Storage: collapsing queue. Entry 0 is always oldest. Each entry holds:
  - uop;
  - prs1/prs2;
  - rdy1/rdy2.
- Enqueue: the accepted uop writes the first free slot (index count - issued_this_cycle).
- disp_ready_o = (count_o != DEPTH). It is combinational from registered count only; an issue in the same cycle does not raise it.
- Handshake: an accept occurs when disp_valid_i && disp_ready_o. Dispatch holds its payload until accepted.
- Wakeup, every cycle with wb_valid_i:
  - Each valid entry with !rdyN && prsN==wb_i.prd sets rdyN=1 and stores wb_i.rdval into rsNval.
  - The same compare applies to the uop being enqueued that cycle. Both operands may wake from one broadcast.
- Select: the lowest-index valid entry with rdy1&&rdy2, evaluated on registered state only. Same-cycle wakeup makes an entry eligible next cycle.
- Issue: on the clock edge after select, fuinput_o = selected uop and issue_valid_o=1.
  - Otherwise issue_valid_o=0. fuinput_o holds its last value.
  - The ALU always accepts, so there is no backpressure on the issue side.
- Collapse: entries above the issued index shift down by one in the same edge. Ordering is preserved.
- Latency:
  - A uop dispatched with both operands ready at cycle T is selectable at T+1 and has issue_valid_o=1 at T+2.
  - A uop woken at cycle T has issue_valid_o=1 at T+2.
- count_o next = count + accept - issue.
- Simultaneous accept and issue when full: accept is blocked because disp_ready_o=0; the issue proceeds.
- flush_i (synchronous, highest priority):
  - At the next edge all valid bits clear, count_o=0 and issue_valid_o=0.
  - A dispatch presented during flush is dropped.
  - A wakeup during flush has no effect.
- Reset mid-operation: immediate return to reset state regardless of clk.
- A wakeup tag of an already-ready operand is ignored; the captured value is not overwritten.

Test Plan:
- Ready dispatch: ADD with rs1val=5, rs2val=7, both rdy, accepted at cycle 1 -> issue_valid_o=1 at cycle 3 with fuinput_o.rs1val=5, rs2val=7; count_o returns to 0.
- Wakeup capture: dispatch with prs2=12, rdy2=0, then wb_valid_i with prd=12, rdval=0xDEAD at cycle 4 -> issue at cycle 6 with rs2val=0xDEAD. A broadcast of prd=13 causes no issue.
- Age order: A (waiting on tag 3), B and C both ready -> B issues before C. After tag 3 wakes, A issues next even though younger uops exist.
- Full: 8 non-ready dispatches -> disp_ready_o=0 and count_o=8. A ninth is held until one wakes and issues; disp_ready_o rises the cycle after the issue.
- Dispatch/wakeup collision: dispatch with prs1=9, rdy1=0 in the same cycle as a wb of prd=9, rdval=42 -> entry captures 42 and issues two cycles later.
- Flush and reset: 5 entries queued, flush_i pulse -> count_o=0, no issue_valid_o afterward. rstn low mid-burst -> outputs go to 0 asynchronously.

Source files
------------

// File: rtl/alu_issue_queue.sv
// Data-capture issue queue feeding the single-cycle ALU.
// Collapsing storage: entry 0 is always the oldest, and occupancy is tracked by
// a count, so an entry is valid exactly when its index is below that count.

package alu_iq_pkg;
    localparam int XLEN  = 32;
    localparam int TAG_W = 6;

    typedef struct packed {
        logic [3:0]       op;
        logic [TAG_W-1:0] prd;
        logic [XLEN-1:0]  rs1val;
        logic [XLEN-1:0]  rs2val;
    } fu_input_t;

    typedef struct packed {
        logic [TAG_W-1:0] prd;
        logic [XLEN-1:0]  rdval;
    } fu_output_t;
endpackage

module alu_issue_queue
    import alu_iq_pkg::fu_input_t, alu_iq_pkg::fu_output_t;
#(
    parameter int DEPTH = 8,
    parameter int PRW   = 6
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     flush_i,
    input  logic                     disp_valid_i,
    output logic                     disp_ready_o,
    input  fu_input_t                disp_uop_i,
    input  logic [PRW-1:0]           disp_prs1_i,
    input  logic [PRW-1:0]           disp_prs2_i,
    input  logic                     disp_rs1_rdy_i,
    input  logic                     disp_rs2_rdy_i,
    input  logic                     wb_valid_i,
    input  fu_output_t               wb_i,
    output logic                     issue_valid_o,
    output fu_input_t                fuinput_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int IW = $clog2(DEPTH);
    localparam int CW = IW + 1;

    // Registered queue state
    fu_input_t        q_uop  [DEPTH];
    logic [PRW-1:0]   q_prs1 [DEPTH];
    logic [PRW-1:0]   q_prs2 [DEPTH];
    logic [DEPTH-1:0] q_rdy1;
    logic [DEPTH-1:0] q_rdy2;
    logic [CW-1:0]    count_q;

    // Entries after this cycle's wakeup, before collapse/enqueue
    fu_input_t        w_uop  [DEPTH];
    logic [DEPTH-1:0] w_rdy1;
    logic [DEPTH-1:0] w_rdy2;

    // Next-state entries
    fu_input_t        n_uop  [DEPTH];
    logic [PRW-1:0]   n_prs1 [DEPTH];
    logic [PRW-1:0]   n_prs2 [DEPTH];
    logic [DEPTH-1:0] n_rdy1;
    logic [DEPTH-1:0] n_rdy2;

    // Incoming dispatch after wakeup
    fu_input_t        d_uop;
    logic             d_rdy1;
    logic             d_rdy2;

    logic [PRW-1:0]   wb_tag;
    logic [DEPTH-1:0] in_use;
    logic             sel_found;
    logic [IW-1:0]    sel_idx;
    logic             accept;
    logic             issue_fire;
    logic [CW-1:0]    enq_idx;
    logic [CW-1:0]    count_n;

    assign wb_tag       = PRW'(wb_i.prd);
    assign count_o      = count_q;
    assign disp_ready_o = (count_q != CW'(DEPTH));
    assign accept       = disp_valid_i && disp_ready_o && !flush_i;
    assign issue_fire   = sel_found && !flush_i;
    assign enq_idx      = count_q - CW'(issue_fire);
    assign count_n      = count_q + CW'(accept) - CW'(issue_fire);

    // Oldest-first select over registered state; a wakeup this cycle only counts next cycle
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        in_use    = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            in_use[i] = (CW'(i) < count_q);
            if (in_use[i] && q_rdy1[i] && q_rdy2[i]) begin
                sel_found = 1'b1;
                sel_idx   = IW'(i);
            end
        end
    end

    // Capture broadcast values into waiting operands of stored entries and of the incoming uop
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            w_uop[i]  = q_uop[i];
            w_rdy1[i] = q_rdy1[i];
            w_rdy2[i] = q_rdy2[i];
            if (wb_valid_i && !q_rdy1[i] && (q_prs1[i] == wb_tag)) begin
                w_rdy1[i]        = 1'b1;
                w_uop[i].rs1val  = wb_i.rdval;
            end
            if (wb_valid_i && !q_rdy2[i] && (q_prs2[i] == wb_tag)) begin
                w_rdy2[i]        = 1'b1;
                w_uop[i].rs2val  = wb_i.rdval;
            end
        end
        d_uop  = disp_uop_i;
        d_rdy1 = disp_rs1_rdy_i;
        d_rdy2 = disp_rs2_rdy_i;
        if (wb_valid_i && !disp_rs1_rdy_i && (disp_prs1_i == wb_tag)) begin
            d_rdy1       = 1'b1;
            d_uop.rs1val = wb_i.rdval;
        end
        if (wb_valid_i && !disp_rs2_rdy_i && (disp_prs2_i == wb_tag)) begin
            d_rdy2       = 1'b1;
            d_uop.rs2val = wb_i.rdval;
        end
    end

    // Close the gap left by the issued entry, then drop the accepted uop into the first free slot
    always_comb begin
        logic [IW-1:0] src;
        for (int i = 0; i < DEPTH; i++) begin
            src = IW'(i);
            if (issue_fire && (IW'(i) >= sel_idx) && (i < DEPTH - 1)) begin
                src = IW'(i + 1);
            end
            n_uop[i]  = w_uop[src];
            n_prs1[i] = q_prs1[src];
            n_prs2[i] = q_prs2[src];
            n_rdy1[i] = w_rdy1[src];
            n_rdy2[i] = w_rdy2[src];
            if (accept && (CW'(i) == enq_idx)) begin
                n_uop[i]  = d_uop;
                n_prs1[i] = disp_prs1_i;
                n_prs2[i] = disp_prs2_i;
                n_rdy1[i] = d_rdy1;
                n_rdy2[i] = d_rdy2;
            end
        end
    end

    // Entry payload storage; contents above the count are don't-care, so no reset is needed
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            q_uop[i]  <= n_uop[i];
            q_prs1[i] <= n_prs1[i];
            q_prs2[i] <= n_prs2[i];
        end
        q_rdy1 <= n_rdy1;
        q_rdy2 <= n_rdy2;
    end

    // Occupancy and the registered issue port; flush wins over everything but reset
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            count_q       <= '0;
            issue_valid_o <= 1'b0;
            fuinput_o     <= '0;
        end else if (flush_i) begin
            count_q       <= '0;
            issue_valid_o <= 1'b0;
        end else begin
            count_q       <= count_n;
            issue_valid_o <= issue_fire;
            if (issue_fire) begin
                fuinput_o <= q_uop[sel_idx];
            end
        end
    end

endmodule
